// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encodings,
// mstatus field positions and interrupt cause codes.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int IRQ_SW_CAUSE    = 3;
  localparam int IRQ_TIMER_CAUSE = 7;
  localparam int IRQ_EXT_CAUSE   = 11;

  // Writable bits of mie: the three machine-level interrupt enables.
  localparam logic [31:0] MIE_MASK = (32'd1 << IRQ_SW_CAUSE) |
                                     (32'd1 << IRQ_TIMER_CAUSE) |
                                     (32'd1 << IRQ_EXT_CAUSE);

endpackage

// File: rtl/csr_counter64.sv
// Free-running performance counter with 32-bit half writes.
// A half write in the same cycle wins over the increment; the other half holds.
module csr_counter64
  import csr_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [31:0] cnt_lo,
  output logic [31:0] cnt_hi
);

  generate
    if (CNT_W == 64) begin : g_64
      logic [63:0] cnt;
      always_ff @(posedge clk) begin
        if (reset)      cnt <= '0;
        else if (wr_lo) cnt[31:0] <= wdata;
        else if (wr_hi) cnt[63:32] <= wdata;
        else if (inc)   cnt <= cnt + 64'd1;
      end
      assign cnt_lo = cnt[31:0];
      assign cnt_hi = cnt[63:32];
    end else begin : g_32
      // No upper half: a write to it is discarded but still holds the count.
      logic [31:0] cnt;
      always_ff @(posedge clk) begin
        if (reset)              cnt <= '0;
        else if (wr_lo)         cnt <= wdata;
        else if (!wr_hi && inc) cnt <= cnt + 32'd1;
      end
      assign cnt_lo = cnt;
      assign cnt_hi = '0;
    end
  endgenerate

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR unit: CSRRW/RS/RC access, counters, trap entry / mret,
// interrupt gating and illegal-access detection.
module csr_file_m
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MISA_VAL  = 32'h4000_1100,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int          CNT_W     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic        csr_src_zero,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        mret,
  input  logic        irq_sw,
  input  logic        irq_timer,
  input  logic        irq_ext,
  output logic        irq_req,
  output logic [31:0] trap_vector,
  output logic [31:0] epc
);

  csr_op_e op;
  assign op = csr_op_e'(csr_op);

  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
  logic [31:0] mstatus_rd, mip_rd, old_val, new_val;
  logic        impl, we, wr_ok, evt;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = st_mie;
    mstatus_rd[MSTATUS_MPIE] = st_mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mip_rd = '0;
    mip_rd[IRQ_SW_CAUSE]    = irq_sw;
    mip_rd[IRQ_TIMER_CAUSE] = irq_timer;
    mip_rd[IRQ_EXT_CAUSE]   = irq_ext;
  end

  always_comb begin
    old_val = '0;
    impl    = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   old_val = mstatus_rd;
      CSR_MISA:      old_val = MISA_VAL;
      CSR_MIE:       old_val = mie_q;
      CSR_MTVEC:     old_val = mtvec_q & ~32'h2;
      CSR_MSCRATCH:  old_val = mscratch_q;
      CSR_MEPC:      old_val = mepc_q;
      CSR_MCAUSE:    old_val = mcause_q;
      CSR_MTVAL:     old_val = mtval_q;
      CSR_MIP:       old_val = mip_rd;
      CSR_MCYCLE:    old_val = mcycle_lo;
      CSR_MCYCLEH:   old_val = mcycle_hi;
      CSR_MINSTRET:  old_val = minstret_lo;
      CSR_MINSTRETH: old_val = minstret_hi;
      CSR_MHARTID:   old_val = HART_ID;
      default:       impl    = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      CSR_OP_RW: new_val = csr_wdata;
      CSR_OP_RS: new_val = old_val | csr_wdata;
      CSR_OP_RC: new_val = old_val & ~csr_wdata;
      default:   new_val = old_val;
    endcase
  end

  assign we          = (op == CSR_OP_RW) ||
                       (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !csr_src_zero);
  assign csr_illegal = (op != CSR_OP_NONE) &&
                       (!impl || (we && (csr_addr[11:10] == 2'b11)));
  assign csr_rdata   = (op != CSR_OP_NONE) ? old_val : 32'd0;
  assign wr_ok       = we && !csr_illegal;
  // Trap/mret own the trap-state registers this cycle; software writes there are dropped.
  assign evt         = trap_valid || mret;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mie  <= 1'b0;
      st_mpie <= 1'b0;
    end else if (trap_valid) begin
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (wr_ok && csr_addr == CSR_MSTATUS) begin
      st_mie  <= new_val[MSTATUS_MIE];
      st_mpie <= new_val[MSTATUS_MPIE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_valid) begin
      mepc_q   <= {trap_pc[31:2], 2'b00};
      mcause_q <= trap_cause;
      mtval_q  <= trap_tval;
    end else if (wr_ok && !evt) begin
      if (csr_addr == CSR_MEPC)   mepc_q   <= {new_val[31:2], 2'b00};
      if (csr_addr == CSR_MCAUSE) mcause_q <= new_val;
      if (csr_addr == CSR_MTVAL)  mtval_q  <= new_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
    end else if (wr_ok) begin
      if (csr_addr == CSR_MIE)      mie_q      <= new_val & MIE_MASK;
      if (csr_addr == CSR_MTVEC)    mtvec_q    <= new_val;
      if (csr_addr == CSR_MSCRATCH) mscratch_q <= new_val;
    end
  end

  csr_counter64 #(.CNT_W(CNT_W)) u_mcycle (
    .clk    (clk),
    .reset  (reset),
    .inc    (1'b1),
    .wr_lo  (wr_ok && csr_addr == CSR_MCYCLE),
    .wr_hi  (wr_ok && csr_addr == CSR_MCYCLEH),
    .wdata  (new_val),
    .cnt_lo (mcycle_lo),
    .cnt_hi (mcycle_hi)
  );

  csr_counter64 #(.CNT_W(CNT_W)) u_minstret (
    .clk    (clk),
    .reset  (reset),
    .inc    (instr_retire),
    .wr_lo  (wr_ok && csr_addr == CSR_MINSTRET),
    .wr_hi  (wr_ok && csr_addr == CSR_MINSTRETH),
    .wdata  (new_val),
    .cnt_lo (minstret_lo),
    .cnt_hi (minstret_hi)
  );

  logic [31:0] tvec_base;
  assign tvec_base   = {mtvec_q[31:2], 2'b00};
  // Vectored mode offsets only interrupts, by 4 * cause.
  assign trap_vector = (mtvec_q[0] && trap_cause[31]) ?
                       tvec_base + {25'd0, trap_cause[4:0], 2'b00} : tvec_base;
  assign irq_req     = st_mie && |(mip_rd & mie_q);
  assign epc         = mepc_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Directed bench for csr_file_m: access ops, counters, traps, mret, priority and reset.
module tb_csr_file_m;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic        csr_src_zero;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_retire;
  logic        trap_valid;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        mret;
  logic        irq_sw, irq_timer, irq_ext;
  logic        irq_req;
  logic [31:0] trap_vector, epc;

  int checks = 0;
  int errors = 0;

  csr_file_m dut (
    .clk          (clk),
    .reset        (reset),
    .csr_addr     (csr_addr),
    .csr_op       (csr_op),
    .csr_src_zero (csr_src_zero),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .trap_tval    (trap_tval),
    .mret         (mret),
    .irq_sw       (irq_sw),
    .irq_timer    (irq_timer),
    .irq_ext      (irq_ext),
    .irq_req      (irq_req),
    .trap_vector  (trap_vector),
    .epc          (epc)
  );

  always #10 clk = ~clk;

  task automatic drv(input logic [11:0] a, input logic [1:0] op,
                     input logic [31:0] d, input logic z);
    csr_addr = a; csr_op = op; csr_wdata = d; csr_src_zero = z;
  endtask

  // Non-writing read: RS with a zero source.
  task automatic rd(input logic [11:0] a);
    drv(a, 2'b10, 32'h0, 1'b1);
    #1;
  endtask

  task automatic idle;
    drv(12'h0, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; instr_retire = 1'b0; trap_valid = 1'b0; mret = 1'b0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;
    idle;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    rd(12'h301);
    checks++; if (csr_rdata !== 32'h4000_1100) begin errors++; $display("FAIL misa got %h exp %h", csr_rdata, 32'h4000_1100); end
    checks++; if (csr_illegal !== 1'b0) begin errors++; $display("FAIL misa_illegal got %b exp 0", csr_illegal); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h0000_1800) begin errors++; $display("FAIL mstatus_rst got %h exp %h", csr_rdata, 32'h1800); end
    checks++; if (irq_req !== 1'b0 || epc !== 32'h0) begin errors++; $display("FAIL rst_outputs got irq %b epc %h exp 0 0", irq_req, epc); end
    cyc; cyc;
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'd2) begin errors++; $display("FAIL mcycle_rst got %h exp %h", csr_rdata, 32'd2); end
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL mcycleh_rst got %h exp 0", csr_rdata); end
  endtask

  task automatic test_setclear;
    drv(12'h340, 2'b01, 32'hA5A5_0000, 1'b0); #1;
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mscratch_rw_old got %h exp 0", csr_rdata); end
    cyc;
    drv(12'h340, 2'b10, 32'h0000_00FF, 1'b0); #1;
    checks++; if (csr_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL mscratch_rs_old got %h exp %h", csr_rdata, 32'hA5A5_0000); end
    cyc;
    drv(12'h340, 2'b11, 32'hFFFF_FFFF, 1'b1); #1;
    checks++; if (csr_rdata !== 32'hA5A5_00FF) begin errors++; $display("FAIL mscratch_rs_new got %h exp %h", csr_rdata, 32'hA5A5_00FF); end
    cyc;
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hA5A5_00FF) begin errors++; $display("FAIL mscratch_rc_zero got %h exp %h", csr_rdata, 32'hA5A5_00FF); end
    drv(12'h340, 2'b11, 32'h0000_00F0, 1'b0);
    cyc;
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hA5A5_000F) begin errors++; $display("FAIL mscratch_rc got %h exp %h", csr_rdata, 32'hA5A5_000F); end
  endtask

  task automatic test_counter;
    drv(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0);
    cyc;
    drv(12'hB80, 2'b01, 32'h0, 1'b0);
    cyc;
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_hold got %h exp %h", csr_rdata, 32'hFFFF_FFFF); end
    cyc;
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'd1) begin errors++; $display("FAIL mcycleh_carry got %h exp 1", csr_rdata); end
    cyc;
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'd1) begin errors++; $display("FAIL mcycle_wrap got %h exp 1", csr_rdata); end
    instr_retire = 1'b1;
    drv(12'hB02, 2'b01, 32'h10, 1'b0);
    cyc;
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h10) begin errors++; $display("FAIL minstret_wr got %h exp 10", csr_rdata); end
    cyc;
    instr_retire = 1'b0;
    cyc;
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h11) begin errors++; $display("FAIL minstret_inc got %h exp 11", csr_rdata); end
  endtask

  task automatic test_illegal;
    drv(12'hF14, 2'b01, 32'h5, 1'b0); #1;
    checks++; if (csr_illegal !== 1'b1) begin errors++; $display("FAIL mhartid_wr_illegal got %b exp 1", csr_illegal); end
    cyc;
    rd(12'hF14);
    checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin errors++; $display("FAIL mhartid_rd got ill %b data %h exp 0 0", csr_illegal, csr_rdata); end
    rd(12'h7C0);
    checks++; if (csr_illegal !== 1'b1 || csr_rdata !== 32'h0) begin errors++; $display("FAIL unimpl got ill %b data %h exp 1 0", csr_illegal, csr_rdata); end
    drv(12'h340, 2'b00, 32'h0, 1'b0); #1;
    checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h0) begin errors++; $display("FAIL op_none got ill %b data %h exp 0 0", csr_illegal, csr_rdata); end
    drv(12'h301, 2'b01, 32'h0, 1'b0); #1;
    checks++; if (csr_illegal !== 1'b0 || csr_rdata !== 32'h4000_1100) begin errors++; $display("FAIL misa_wr got ill %b data %h exp 0 40001100", csr_illegal, csr_rdata); end
    idle;
    cyc;
  endtask

  task automatic test_irq_trap;
    drv(12'h305, 2'b01, 32'h203, 1'b0); cyc;
    drv(12'h304, 2'b01, 32'hFFFF_FFFF, 1'b0); cyc;
    rd(12'h304);
    checks++; if (csr_rdata !== 32'h888) begin errors++; $display("FAIL mie_mask got %h exp 888", csr_rdata); end
    rd(12'h305);
    checks++; if (csr_rdata !== 32'h201) begin errors++; $display("FAIL mtvec_bit1 got %h exp 201", csr_rdata); end
    drv(12'h304, 2'b01, 32'h80, 1'b0); cyc;
    drv(12'h300, 2'b01, 32'h8, 1'b0); cyc;
    idle; irq_timer = 1'b1; #1;
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL irq_req_set got %b exp 1", irq_req); end
    rd(12'h344);
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("FAIL mip got %h exp 80", csr_rdata); end
    idle;
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h107; trap_tval = 32'hDEAD_BEEF; #1;
    checks++; if (trap_vector !== 32'h21C) begin errors++; $display("FAIL trap_vector_irq got %h exp 21c", trap_vector); end
    cyc;
    trap_valid = 1'b0; trap_cause = 32'h7; #1;
    checks++; if (trap_vector !== 32'h200) begin errors++; $display("FAIL trap_vector_exc got %h exp 200", trap_vector); end
    checks++; if (epc !== 32'h104) begin errors++; $display("FAIL trap_epc got %h exp 104", epc); end
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_req_masked got %b exp 0", irq_req); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL trap_mstatus got %h exp 1880", csr_rdata); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause got %h exp 80000007", csr_rdata); end
    rd(12'h343);
    checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL trap_mtval got %h exp deadbeef", csr_rdata); end
    idle;
  endtask

  task automatic test_mret;
    mret = 1'b1;
    cyc;
    mret = 1'b0;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h exp 1888", csr_rdata); end
    checks++; if (epc !== 32'h104) begin errors++; $display("FAIL mret_epc got %h exp 104", epc); end
    checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL mret_irq got %b exp 1", irq_req); end
    irq_timer = 1'b0; irq_ext = 1'b1; #1;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL irq_ext_disabled got %b exp 0", irq_req); end
    irq_ext = 1'b0;
    idle;
  endtask

  task automatic test_trap_priority;
    drv(12'h341, 2'b01, 32'h500, 1'b0);
    trap_valid = 1'b1; trap_pc = 32'h40; trap_cause = 32'h2; trap_tval = 32'h0;
    cyc;
    drv(12'h340, 2'b01, 32'h1234, 1'b0);
    cyc;
    trap_valid = 1'b0;
    rd(12'h341);
    checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL prio_mepc got %h exp 40", csr_rdata); end
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h1234) begin errors++; $display("FAIL prio_mscratch got %h exp 1234", csr_rdata); end
    drv(12'h300, 2'b01, 32'h88, 1'b0);
    mret = 1'b1;
    cyc;
    mret = 1'b0;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL prio_mret_mstatus got %h exp 1880", csr_rdata); end
    idle;
  endtask

  task automatic test_reset_with_trap;
    reset = 1'b1;
    trap_valid = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h300; trap_tval = 32'h55;
    irq_sw = 1'b1; irq_timer = 1'b1; irq_ext = 1'b1;
    idle;
    cyc;
    reset = 1'b0; trap_valid = 1'b0;
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst2_mcycle got %h exp 0", csr_rdata); end
    rd(12'h341);
    checks++; if (csr_rdata !== 32'h0 || epc !== 32'h0) begin errors++; $display("FAIL rst2_mepc got %h epc %h exp 0", csr_rdata, epc); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst2_mcause got %h exp 0", csr_rdata); end
    rd(12'h343);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst2_mtval got %h exp 0", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL rst2_mstatus got %h exp 1800", csr_rdata); end
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL rst2_mscratch got %h exp 0", csr_rdata); end
    rd(12'h305);
    checks++; if (csr_rdata !== 32'h0 || trap_vector !== 32'h0) begin errors++; $display("FAIL rst2_mtvec got %h vec %h exp 0 0", csr_rdata, trap_vector); end
    rd(12'h304);
    checks++; if (csr_rdata !== 32'h0 || irq_req !== 1'b0) begin errors++; $display("FAIL rst2_mie got %h irq %b exp 0 0", csr_rdata, irq_req); end
    idle;
  endtask

  initial begin
    test_reset;
    test_setclear;
    test_counter;
    test_illegal;
    test_irq_trap;
    test_mret;
    test_trap_priority;
    test_reset_with_trap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
